// File: rtl/uar_rx_cfg.sv
// uar_rx_cfg: configurable UART receiver (5..9 data bits, none/even/odd parity, 1/2 stop bits).
// Define UAR_RX_MAJORITY_EN to decide each bit by 2-of-3 majority at cnt 6/7/8 instead of cnt 7.
module uar_rx_cfg #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk_16x,
  input  logic                 rst_n,
  input  logic                 ser_in,
  input  logic                 dout_ack,
  output logic [DATA_BITS-1:0] dout_byte,
  output logic                 dout_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam bit         ODD_PAR  = (PARITY_MODE == 2);

  state_e               state_q, state_d;
  logic                 ser_m, ser_s, ser_prev;
  logic [3:0]           cnt_q, cnt_d, bit_q, bit_d;
  logic                 stop2_q, stop2_d, par_q, par_d, frm_q, frm_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bit_dec, at_dec, at_end, fall, done;

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      ser_m    <= 1'b1;
      ser_s    <= 1'b1;
      ser_prev <= 1'b1;
    end else begin
      ser_m    <= ser_in;
      ser_s    <= ser_m;
      ser_prev <= ser_s;
    end
  end

  assign fall = ser_prev & ~ser_s;

`ifdef UAR_RX_MAJORITY_EN
  localparam logic [3:0] DEC_CNT = 4'd8;
  logic [1:0] hist_q;  // ser_s one and two cycles back (cnt 7 and 6 at the decision)

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], ser_s};
  end

  assign bit_dec = (hist_q[1] & hist_q[0]) | (hist_q[1] & ser_s) | (hist_q[0] & ser_s);
`else
  localparam logic [3:0] DEC_CNT = 4'd7;
  assign bit_dec = ser_s;
`endif

  assign at_dec = (cnt_q == DEC_CNT);
  assign at_end = (cnt_q == 4'hF);
  assign busy   = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    bit_d   = bit_q;
    stop2_d = stop2_q;
    shift_d = shift_q;
    par_d   = par_q;
    frm_d   = frm_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = StStart;
          par_d   = 1'b0;
          frm_d   = 1'b0;
          stop2_d = 1'b0;
        end
      end
      StStart: begin
        if (at_dec && bit_dec) begin
          state_d = StIdle;  // line back high mid start bit: glitch, not a frame
        end else if (at_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (at_dec) shift_d = {bit_dec, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == LAST_BIT) state_d = (PARITY_MODE != 0) ? StParity : StStop;
          else                   bit_d   = bit_q + 4'd1;
        end
      end
      StParity: begin
        if (at_dec) par_d = bit_dec ^ (^shift_q) ^ ODD_PAR;
        if (at_end) state_d = StStop;
      end
      StStop: begin
        if (at_dec && !bit_dec) frm_d = 1'b1;
        if (STOP_BITS == 2 && !stop2_q) begin
          if (at_end) stop2_d = 1'b1;
        end else if (at_dec) begin
          // Finish at mid stop bit so an early next start edge is not missed.
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop2_q <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop2_q <= stop2_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
    end
  end

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      dout_byte   <= '0;
      dout_vld    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      dout_byte  <= shift_q;
      parity_err <= par_q;
      frame_err  <= frm_q | ~bit_dec;
      dout_vld   <= 1'b1;
      if (dout_vld && !dout_ack) overrun_err <= 1'b1;
    end else if (dout_vld && dout_ack) begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uar_rx_cfg.sv
// Bench for uar_rx_cfg: an 8N1 instance and a 7E2 instance driven with serial frames built
// from data/parity/stop rules and checked against arithmetic expectations.
module tb_uar_rx_cfg;

`ifdef UAR_RX_MAJORITY_EN
  localparam int DEC = 8;
`else
  localparam int DEC = 7;
`endif
  localparam int LAT = 16 * 9 + DEC + 1;  // 8N1 START entry -> dout_vld

  logic       clk_16x = 1'b0;
  logic       rst_n;
  logic       ser8, ack8, ser7, ack7;
  logic [7:0] byte8;
  logic [6:0] byte7;
  logic       vld8, perr8, ferr8, ovr8, busy8;
  logic       vld7, perr7, ferr7, ovr7, busy7;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk_16x = ~clk_16x;

  uar_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut8 (
    .clk_16x(clk_16x), .rst_n(rst_n), .ser_in(ser8), .dout_ack(ack8), .dout_byte(byte8),
    .dout_vld(vld8), .parity_err(perr8), .frame_err(ferr8), .overrun_err(ovr8), .busy(busy8)
  );

  uar_rx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut7 (
    .clk_16x(clk_16x), .rst_n(rst_n), .ser_in(ser7), .dout_ack(ack7), .dout_byte(byte7),
    .dout_vld(vld7), .parity_err(perr7), .frame_err(ferr7), .overrun_err(ovr7), .busy(busy7)
  );

  // Line image of one frame: bit 0 = start, then data LSB first, parity, stop bits.
  function automatic logic [15:0] build(input logic [8:0] data, input int nb, input int pm,
                                        input int sb, input bit par_flip,
                                        input logic [1:0] stop_low, output int n);
    logic [15:0] b;
    int p, ones;
    b = '0;
    p = 1;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      b[p] = data[i];
      ones += int'(data[i]);
      p++;
    end
    if (pm != 0) begin
      b[p] = ((ones % 2 == 1) ^ (pm == 2)) ^ par_flip;
      p++;
    end
    for (int s = 0; s < sb; s++) begin
      b[p] = ~stop_low[s];
      p++;
    end
    n = p;
    return b;
  endfunction

  task automatic set_ser(input int which, input logic v);
    if (which == 0) ser8 = v;
    else            ser7 = v;
  endtask

  // Called at posedge+1; returns at posedge+1 with the line idle high.
  task automatic drive_bits(input int which, input logic [15:0] bits, input int n,
                            input int glitch_lo, input int glitch_hi);
    for (int i = 0; i < n; i++) begin
      set_ser(which, bits[i]);
      for (int j = 1; j <= 16; j++) begin
        @(posedge clk_16x);
        #1;
        if (i >= glitch_lo && i <= glitch_hi) begin
          if (j == 8)      set_ser(which, ~bits[i]);
          else if (j == 9) set_ser(which, bits[i]);
        end
      end
    end
    set_ser(which, 1'b1);
  endtask

  task automatic pulse_ack(input int which);
    if (which == 0) ack8 = 1'b1;
    else            ack7 = 1'b1;
    @(posedge clk_16x);
    #1;
    ack8 = 1'b0;
    ack7 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ser8 = 1'b1; ser7 = 1'b1; ack8 = 1'b0; ack7 = 1'b0;
    repeat (3) @(posedge clk_16x);
    #1;
    n_chk++;
    if ({byte8, vld8, perr8, ferr8, ovr8, busy8} !== 13'd0)
      $display("FAIL reset_dut8: got %b want 0", {byte8, vld8, perr8, ferr8, ovr8, busy8});
    else n_pass++;
    n_chk++;
    if ({byte7, vld7, perr7, ferr7, ovr7, busy7} !== 12'd0)
      $display("FAIL reset_dut7: got %b want 0", {byte7, vld7, perr7, ferr7, ovr7, busy7});
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(posedge clk_16x);
    #1;
  endtask

  task automatic test_8n1();
    logic [15:0] b;
    int n, k;
    b = build(9'h0A5, 8, 0, 1, 1'b0, 2'b00, n);
    k = 0;
    fork
      drive_bits(0, b, n, 1, 0);
      while (!vld8 && k < 400) begin
        @(posedge clk_16x);
        #1;
        k++;
      end
    join
    n_chk++;
    if (k !== 3 + LAT) $display("FAIL 8n1_latency: got %0d want %0d", k, 3 + LAT);
    else n_pass++;
    n_chk++;
    if ({byte8, perr8, ferr8} !== {8'hA5, 2'b00})
      $display("FAIL 8n1_word: got %h p%b f%b want a5 p0 f0", byte8, perr8, ferr8);
    else n_pass++;
    pulse_ack(0);
    n_chk++;
    if (vld8 !== 1'b0) $display("FAIL 8n1_ack: got vld %b want 0", vld8);
    else n_pass++;
  endtask

  task automatic test_false_start();
    logic [15:0] b;
    int n;
    logic busy_mid;
    bit seen_vld;
    seen_vld = 0;
    busy_mid = 1'b0;
    ser8 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk_16x);
      #1;
      if (k == 4) begin
        busy_mid = busy8;
        ser8 = 1'b1;
      end
      if (vld8) seen_vld = 1;
    end
    n_chk++;
    if ({busy_mid, busy8, seen_vld} !== 3'b100)
      $display("FAIL false_start: got busy %b->%b vld %b want 1->0 0", busy_mid, busy8, seen_vld);
    else n_pass++;
    b = build(9'h03C, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 0);
    n_chk++;
    if ({vld8, byte8, perr8, ferr8} !== {1'b1, 8'h3C, 2'b00})
      $display("FAIL after_false_start: got v%b %h p%b f%b want v1 3c p0 f0",
               vld8, byte8, perr8, ferr8);
    else n_pass++;
    pulse_ack(0);
  endtask

  task automatic test_frame_err();
    logic [15:0] b;
    int n;
    b = build(9'h081, 8, 0, 1, 1'b0, 2'b01, n);
    drive_bits(0, b, n, 1, 0);
    n_chk++;
    if ({vld8, byte8, perr8, ferr8} !== {1'b1, 8'h81, 2'b01})
      $display("FAIL frame_err: got v%b %h p%b f%b want v1 81 p0 f1", vld8, byte8, perr8, ferr8);
    else n_pass++;
    pulse_ack(0);
  endtask

  task automatic test_parity();
    logic [15:0] b;
    int n;
    for (int f = 0; f < 2; f++) begin
      b = build(9'h035, 7, 1, 2, f[0], 2'b00, n);
      drive_bits(1, b, n, 1, 0);
      n_chk++;
      if ({vld7, byte7, perr7, ferr7} !== {1'b1, 7'h35, f[0], 1'b0})
        $display("FAIL parity_%0d: got v%b %h p%b f%b want v1 35 p%0d f0",
                 f, vld7, byte7, perr7, ferr7, f);
      else n_pass++;
      pulse_ack(1);
      n_chk++;
      if (vld7 !== 1'b0) $display("FAIL parity_ack_%0d: got vld %b want 0", f, vld7);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] b;
    logic [6:0]  data;
    logic [1:0]  sl;
    bit          flip;
    int          n;
    for (int it = 0; it < 10; it++) begin
      data = 7'($urandom_range(0, 127));
      flip = ($urandom_range(0, 3) == 0);
      sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b = build({2'b00, data}, 7, 1, 2, flip, sl, n);
      drive_bits(1, b, n, 1, 0);
      repeat ($urandom_range(2, 20)) @(posedge clk_16x);
      #1;
      n_chk++;
      if ({vld7, byte7, perr7, ferr7} !== {1'b1, data, flip, (sl != 2'b00)})
        $display("FAIL random_%0d: got v%b %h p%b f%b want v1 %h p%b f%b",
                 it, vld7, byte7, perr7, ferr7, data, flip, (sl != 2'b00));
      else n_pass++;
      pulse_ack(1);
      n_chk++;
      if (vld7 !== 1'b0) $display("FAIL random_ack_%0d: got vld %b want 0", it, vld7);
      else n_pass++;
    end
  endtask

  // Second frame completes in the very cycle the first word is acked.
  task automatic test_ack_collide();
    logic [15:0] b;
    int n;
    b = build(9'h00F, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 0);
    b = build(9'h0F0, 8, 0, 1, 1'b0, 2'b00, n);
    fork
      drive_bits(0, b, n, 1, 0);
      begin
        repeat (2 + LAT) @(posedge clk_16x);
        #1;
        ack8 = 1'b1;
        @(posedge clk_16x);
        #1;
        ack8 = 1'b0;
      end
    join
    n_chk++;
    if ({vld8, byte8, ovr8} !== {1'b1, 8'hF0, 1'b0})
      $display("FAIL ack_collide: got v%b %h o%b want v1 f0 o0", vld8, byte8, ovr8);
    else n_pass++;
    pulse_ack(0);
  endtask

  task automatic test_break();
    logic [15:0] b;
    int n;
    bit seen_vld;
    seen_vld = 0;
    ser8 = 1'b0;
    repeat (250) @(posedge clk_16x);
    #1;
    n_chk++;
    if ({vld8, byte8, perr8, ferr8} !== {1'b1, 8'h00, 2'b01})
      $display("FAIL break_frame: got v%b %h p%b f%b want v1 00 p0 f1", vld8, byte8, perr8, ferr8);
    else n_pass++;
    pulse_ack(0);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_16x);
      #1;
      if (vld8 || busy8) seen_vld = 1;
    end
    n_chk++;
    if (seen_vld) $display("FAIL break_hold: got activity 1 want 0");
    else n_pass++;
    ser8 = 1'b1;
    repeat (20) @(posedge clk_16x);
    #1;
    b = build(9'h096, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 0);
    n_chk++;
    if ({vld8, byte8, ferr8} !== {1'b1, 8'h96, 1'b0})
      $display("FAIL after_break: got v%b %h f%b want v1 96 f0", vld8, byte8, ferr8);
    else n_pass++;
    pulse_ack(0);
  endtask

  task automatic test_overrun();
    logic [15:0] b;
    int n;
    b = build(9'h011, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 0);
    n_chk++;
    if ({vld8, byte8, ovr8} !== {1'b1, 8'h11, 1'b0})
      $display("FAIL overrun_first: got v%b %h o%b want v1 11 o0", vld8, byte8, ovr8);
    else n_pass++;
    b = build(9'h022, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 0);
    n_chk++;
    if ({vld8, byte8, ovr8, ferr8} !== {1'b1, 8'h22, 1'b1, 1'b0})
      $display("FAIL overrun: got v%b %h o%b f%b want v1 22 o1 f0", vld8, byte8, ovr8, ferr8);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] b;
    int n;
    b = build(9'h055, 8, 0, 1, 1'b0, 2'b00, n);
    fork
      drive_bits(0, b, n, 1, 0);
      begin
        repeat (60) @(posedge clk_16x);
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({byte8, vld8, perr8, ferr8, ovr8, busy8} !== 13'd0)
          $display("FAIL reset_mid: got %b want 0", {byte8, vld8, perr8, ferr8, ovr8, busy8});
        else n_pass++;
      end
    join
    rst_n = 1'b1;
    repeat (100) @(posedge clk_16x);
    #1;
    n_chk++;
    if ({vld8, busy8} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {vld8, busy8});
    else n_pass++;
    b = build(9'h0C3, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 0);
    n_chk++;
    if ({vld8, byte8, ovr8} !== {1'b1, 8'hC3, 1'b0})
      $display("FAIL reset_recover: got v%b %h o%b want v1 c3 o0", vld8, byte8, ovr8);
    else n_pass++;
    pulse_ack(0);
  endtask

`ifdef UAR_RX_MAJORITY_EN
  task automatic test_majority();
    logic [15:0] b;
    int n;
    b = build(9'h05A, 8, 0, 1, 1'b0, 2'b00, n);
    drive_bits(0, b, n, 1, 8);
    n_chk++;
    if ({vld8, byte8, perr8, ferr8} !== {1'b1, 8'h5A, 2'b00})
      $display("FAIL majority: got v%b %h p%b f%b want v1 5a p0 f0", vld8, byte8, perr8, ferr8);
    else n_pass++;
    pulse_ack(0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_8n1();
    test_false_start();
    test_frame_err();
    test_parity();
    test_random();
    test_ack_collide();
    test_break();
    test_overrun();
    test_reset_mid_frame();
`ifdef UAR_RX_MAJORITY_EN
    test_majority();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uar_rx_cfg.md
# uar_rx_cfg

Parametrised UART receive block on the 16x oversample clock. It is the configurable successor to the fixed 8N1 receiver: data width, parity and stop-bit count are set per instance. It adds false-start rejection, framing, parity and overrun error flags, and a held valid/ack output handshake in place of a fixed-length ready pulse. It sits between the serial input pin and the byte consumer (FIFO or register bank).

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9; LSB first on the line.
- `PARITY_MODE`, default 0: 0 = no parity, 1 = even parity, 2 = odd parity.
- `STOP_BITS`, default 1: 1 or 2.
- `clk_16x`, input, 1: receive clock at 16x the baud rate.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `ser_in`, input, 1: asynchronous serial line; idles high.
- `dout_ack`, input, 1: consumer accept; consumes the word in the cycle `dout_vld & dout_ack`.
- `dout_byte`, output, DATA_BITS: received data word, LSB = first bit on the line.
- `dout_vld`, output, 1: word available; held high until acked.
- `parity_err`, output, 1: parity mismatch on the word currently presented; qualified by `dout_vld`.
- `frame_err`, output, 1: a stop bit was sampled low on the presented word; qualified by `dout_vld`.
- `overrun_err`, output, 1: sticky; set when a frame completes while `dout_vld=1` and not acked that cycle; cleared only by reset.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- `ser_in` passes through a 2-flop synchroniser (reset value 1) to give `ser_s`.
- Start detection: a falling edge on `ser_s` (previous 1, current 0).
- Sample counter `cnt` is 4 bits, runs 0..15 and wraps. It is cleared on entering START.
- Bit decision: the sampled value of `ser_s` at `cnt==7`.
- State machine:
  - IDLE -> START on a falling edge.
  - START: at `cnt==7`, a sample of 1 is a false start -> IDLE. A sample of 0 continues. At `cnt==15` -> DATA.
  - DATA: shifts the bit decision into the MSB of the shift register, shifting right. It counts DATA_BITS bits, then goes to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compares the decision with the XOR of the data bits (even parity) or its inverse (odd parity). At the end of the bit -> STOP.
  - STOP: the bit decision is taken at `cnt==7`.
    - If STOP_BITS==2 and this is the first stop bit, wait to `cnt==15` and repeat the STOP decision.
    - At the final stop `cnt==7`: complete the frame and -> IDLE immediately. The line is not held to the end of the stop bit, so a start bit arriving half a bit early is still caught.
  - `frame_err` is set if any stop decision is 0.
- Frame completion (one cycle):
  - `dout_byte`, `parity_err` and `frame_err` load.
  - `dout_vld` sets.
- Completion while `dout_vld=1` and `dout_ack=0`:
  - The new word overwrites the held one.
  - `overrun_err` sets.
  - `dout_vld` stays 1.
- Completion with `dout_vld & dout_ack` in the same cycle: the new word loads, `dout_vld` stays 1, and there is no overrun.
- `dout_ack` while `dout_vld=0` is ignored.
- Reset values: `dout_byte=0`, `dout_vld=0`, `parity_err=0`, `frame_err=0`, `overrun_err=0`, `busy=0`, state IDLE.
- Reset asserted mid-frame discards the partial frame. After release, the block waits for a fresh falling edge.
- A line held low (break) completes one frame with `frame_err=1`. A new frame does not start until the line returns high and then falls again.

## Timing
- Synchroniser plus edge detection: the falling edge is seen 2 `clk_16x` cycles after the `ser_in` fall. START is entered on the next edge.
- Bit n (start = bit 0) is decided at 16·n+7 cycles after START entry.
- `dout_vld` rises 1 cycle after the final stop decision. For 8N1 that is 16·9+7+1 = 152 cycles after START entry.
- `dout_vld` falls in the cycle after the ack cycle.
- `busy` falls in the same cycle that `dout_vld` rises.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `UAR_RX_MAJORITY_EN` defined: the bit decision is the 2-of-3 majority of samples at `cnt` 6, 7 and 8. Every decision point, including the start check, the final-stop completion and the latencies in Timing, moves from `cnt==7` to `cnt==8`. The 8N1 `dout_vld` latency becomes 153 cycles.
- `UAR_RX_MAJORITY_EN` undefined: single sample at `cnt==7`, as described above.

## Test plan
- 8N1, no parity: send 0xA5 at 16x. Expect `dout_byte=0xA5`, `dout_vld` high 152 cycles after START entry, both error flags 0. Ack with `dout_ack` -> `dout_vld` 0 the next cycle.
- DATA_BITS=7, PARITY_MODE=1 (even), STOP_BITS=2: send 0x35 with correct parity 0 -> `parity_err=0`. Send 0x35 with parity bit 1 -> `parity_err=1`, `dout_byte=0x35`.
- False start: `ser_in` low for 4 cycles, then high -> no `dout_vld`, `busy` returns to 0 within 10 cycles. A following 0x3C frame is received correctly.
- Framing: send 0x81 with the stop bit driven 0 -> `frame_err=1`, `dout_byte=0x81`.
- Overrun: send 0x11 then 0x22 back-to-back with `dout_ack=0` -> `dout_byte=0x22`, `overrun_err=1`. Assert `rst_n=0` mid-frame -> all outputs 0.
- With `UAR_RX_MAJORITY_EN`: send 0x5A with a 1-cycle glitch at `cnt==7` of every data bit -> `dout_byte=0x5A`, no errors.
